seq_restoring_div: RTL and testbench

Sequential unsigned restoring divider: one quotient bit per clock, using the same subtract-then-restore primitive as the ALU's add/sub path (subtract the divisor; add it back when the result goes negative). It is the inverse companion of the ALU arithmetic datapath: divide instead of combine. It accepts a dividend and divisor on a start pulse and returns quotient and remainder after WIDTH cycles. It sits beside the combinational arithmetic unit as the multi-cycle DIV/MOD resource.

---
 rtl/seq_restoring_div_if.sv | 13 +
 rtl/seq_restoring_div.sv | 68 ++++++
 tb/tb_seq_restoring_div.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_div_if.sv
// seq_restoring_div_if: start/operand/result bundle for the sequential restoring divider
interface seq_restoring_div_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic busy;
  logic done;
  logic dz;
  modport master(output start, a, b, input q, r, busy, done, dz);
  modport slave(input start, a, b, output q, r, busy, done, dz);
endinterface

// File: rtl/seq_restoring_div.sv
// seq_restoring_div: unsigned restoring divider, one quotient bit per clock
module seq_restoring_div #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  seq_restoring_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH:0] p;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] ps;
  logic [WIDTH:0] d;
  logic [WIDTH:0] pn;
  logic [WIDTH-1:0] qn;
  // trial subtraction; a set sign bit means the divisor did not fit, so restore
  always_comb begin
    ps = {p[WIDTH-1:0], qreg[WIDTH-1]};
    d = ps - {1'b0, b_reg};
    pn = d[WIDTH] ? ps : d;
    qn = {qreg[WIDTH-2:0], ~d[WIDTH]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      b_reg <= '0;
      qreg <= '0;
      p <= '0;
      cnt <= '0;
      bus.q <= '0;
      bus.r <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dz <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && bus.b != '0) begin
          b_reg <= bus.b;
          qreg <= bus.a;
          p <= '0;
          cnt <= CW'(WIDTH);
          bus.dz <= 1'b0;
          bus.busy <= 1'b1;
          state <= RUN;
        end else if (bus.start) begin
          bus.q <= '1;
          bus.r <= bus.a;
          bus.dz <= 1'b1;
          bus.done <= 1'b1;
        end
      end else begin
        p <= pn;
        qreg <= qn;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bus.q <= qn;
          bus.r <= pn[WIDTH-1:0];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_div.sv
// tb_seq_restoring_div: vector table, corner sequences, random and exhaustive checks
module tb_seq_restoring_div;
  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  seq_restoring_div_if #(.WIDTH(W)) bus();
  seq_restoring_div #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } vec_t;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) check("busy_done_overlap", int'(bus.busy && bus.done), 0);
  task automatic run_op(input int a, input int b, output int q, output int r, output int dz,
                        output int lat, output int bz);
    @(negedge clk);
    bus.a = W'(a);
    bus.b = W'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bz = int'(bus.busy);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = int'(bus.q);
    r = int'(bus.r);
    dz = int'(bus.dz);
  endtask
  initial begin
    vec_t tbl[$];
    int q, r, dz, lat, bz, n, a, b;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tbl = '{'{13, 3, 4, 1, 0}, '{15, 1, 15, 0, 0}, '{5, 7, 0, 5, 0}, '{15, 15, 1, 0, 0},
            '{9, 0, 15, 9, 1}, '{6, 2, 3, 0, 0}, '{12, 5, 2, 2, 0}, '{0, 1, 0, 0, 0},
            '{0, 0, 15, 0, 1}, '{14, 4, 3, 2, 0}};
    repeat (2) @(negedge clk);
    check("reset_q", int'(bus.q), 0);
    check("reset_r", int'(bus.r), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_dz", int'(bus.dz), 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, q, r, dz, lat, bz);
      check("tbl_q", q, tbl[i].q);
      check("tbl_r", r, tbl[i].r);
      check("tbl_dz", dz, tbl[i].dz);
      check("tbl_latency", lat, tbl[i].b == 0 ? 0 : W);
      check("tbl_busy", bz, tbl[i].b == 0 ? 0 : 1);
      @(negedge clk);
      check("tbl_done_drop", int'(bus.done), 0);
    end
    // START retriggered while busy must be ignored
    @(negedge clk);
    bus.a = 4'd13;
    bus.b = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 4'd1;
    bus.b = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        n++;
        q = int'(bus.q);
        r = int'(bus.r);
      end
      @(negedge clk);
    end
    check("ignore_done_count", n, 1);
    check("ignore_q", q, 4);
    check("ignore_r", r, 1);
    // asynchronous reset mid-division
    @(negedge clk);
    bus.a = 4'd7;
    bus.b = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_q", int'(bus.q), 0);
    check("arst_r", int'(bus.r), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_dz", int'(bus.dz), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("arst_no_done", n, 0);
    run_op(12, 5, q, r, dz, lat, bz);
    check("post_rst_q", q, 2);
    check("post_rst_r", r, 2);
    // START held high across the DONE cycle
    @(negedge clk);
    bus.a = 4'd14;
    bus.b = 4'd4;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 20);
    check("held1_q", int'(bus.q), 3);
    check("held1_r", int'(bus.r), 2);
    bus.a = 4'd7;
    bus.b = 4'd2;
    @(negedge clk);
    check("held2_accepted", int'(bus.busy), 1);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held2_latency", lat, W);
    check("held2_q", int'(bus.q), 3);
    check("held2_r", int'(bus.r), 1);
    // random operands against plain integer division
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, MAXV));
      b = (i % 10 == 0) ? 0 : int'($urandom_range(0, MAXV));
      run_op(a, b, q, r, dz, lat, bz);
      check("rand_q", q, b == 0 ? MAXV : a / b);
      check("rand_r", r, b == 0 ? a : a % b);
      check("rand_dz", dz, int'(b == 0));
    end
    // exhaustive invariant sweep
    for (int ai = 0; ai <= MAXV; ai++) begin
      for (int bi = 0; bi <= MAXV; bi++) begin
        run_op(ai, bi, q, r, dz, lat, bz);
        if (bi == 0) begin
          check("sweep_dz_q", q, MAXV);
          check("sweep_dz_r", r, ai);
          check("sweep_dz_flag", dz, 1);
        end else begin
          check("sweep_qb_plus_r", q * bi + r, ai);
          check("sweep_r_lt_b", int'(r < bi), 1);
          check("sweep_dz_clear", dz, 0);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
